// File: rtl/rs_uart_pkg.sv
// -----------------------------------------------------------------------------
// rs_uart_pkg
// Shared types and constants for the rs_uart transmitter.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package rs_uart_pkg;

   // Transmitter frame phases
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_t;

   // Parity modes
   localparam int unsigned PAR_NONE = 0;
   localparam int unsigned PAR_EVEN = 1;
   localparam int unsigned PAR_ODD  = 2;

   // 50 MHz clock, 115200 baud
   localparam int unsigned DEFAULT_BAUD_DIV = 434;

   // Parity bit transmitted after the data byte for the given mode
   function automatic logic parity_bit(input logic [7:0] data, input int unsigned mode);
      return (mode == PAR_ODD) ? ~^data : ^data;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rs_baud_tick.sv
// -----------------------------------------------------------------------------
// rs_baud_tick
// Bit-period timer: counts 0..BAUD_DIV-1 while enabled and flags the last
// cycle of each bit period. A clear restarts the period from zero so that the
// first bit of a frame is always full length.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module rs_baud_tick
   import rs_uart_pkg::*;
#(
   parameter int unsigned BAUD_DIV = DEFAULT_BAUD_DIV
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic bit_tick
);

   // BAUD_DIV <= 65535, so the terminal count always fits in 16 bits
   localparam logic [15:0] LAST_COUNT = 16'(BAUD_DIV - 1);

   logic [15:0] count;

   assign bit_tick = enable && (count == LAST_COUNT);

   // Free-running bit-period counter, wrapping after the terminal count
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= (count == LAST_COUNT) ? 16'd0 : count + 16'd1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/rs_uart_tx.sv
// -----------------------------------------------------------------------------
// rs_uart_tx
// UART transmitter: start bit, 8 data bits LSB-first, optional parity,
// STOP_BITS stop bits. Busy is reported on rs_tx_status one cycle after the
// accepting edge; txd and rs_tx_status are both registered.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module rs_uart_tx
   import rs_uart_pkg::*;
#(
   parameter int unsigned BAUD_DIV  = DEFAULT_BAUD_DIV,
   parameter int unsigned PARITY    = PAR_NONE,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rs_tx_start,
   input  logic [7:0] rs_tx_data,
   output logic       rs_tx_status,
   output logic       txd
);

   localparam logic STOP_LAST = 1'(STOP_BITS - 1);

   tx_state_t  state;
   logic [7:0] shreg;
   logic [2:0] bit_idx;
   logic       stop_cnt;
   logic       par_bit;
   logic       accept;
   logic       bit_tick;

   assign accept = (state == ST_IDLE) && rs_tx_start;

   rs_baud_tick #(
      .BAUD_DIV (BAUD_DIV)
   ) u_baud_tick (
      .clk      (clk),
      .reset    (reset),
      .clear    (accept),
      .enable   (rs_tx_status),
      .bit_tick (bit_tick)
   );

   // Frame sequencer; txd changes only here, on bit boundaries or reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         shreg        <= '0;
         bit_idx      <= '0;
         stop_cnt     <= 1'b0;
         par_bit      <= 1'b0;
         txd          <= 1'b1;
         rs_tx_status <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (rs_tx_start) begin
                  shreg        <= rs_tx_data;
                  par_bit      <= parity_bit(rs_tx_data, PARITY);
                  bit_idx      <= '0;
                  stop_cnt     <= 1'b0;
                  txd          <= 1'b0;
                  rs_tx_status <= 1'b1;
                  state        <= ST_START;
               end
            end
            ST_START: begin
               if (bit_tick) begin
                  txd     <= shreg[0];
                  shreg   <= shreg >> 1;
                  bit_idx <= '0;
                  state   <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (bit_tick) begin
                  if (bit_idx == 3'd7) begin
                     if (PARITY != PAR_NONE) begin
                        txd   <= par_bit;
                        state <= ST_PARITY;
                     end else begin
                        txd      <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= ST_STOP;
                     end
                  end else begin
                     txd     <= shreg[0];
                     shreg   <= shreg >> 1;
                     bit_idx <= bit_idx + 3'd1;
                  end
               end
            end
            ST_PARITY: begin
               if (bit_tick) begin
                  txd      <= 1'b1;
                  stop_cnt <= 1'b0;
                  state    <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (bit_tick) begin
                  if (stop_cnt == STOP_LAST) begin
                     rs_tx_status <= 1'b0;
                     state        <= ST_IDLE;
                  end else begin
                     stop_cnt <= stop_cnt + 1'b1;
                  end
               end
            end
            default: begin
               txd          <= 1'b1;
               rs_tx_status <= 1'b0;
               state        <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
